// File: rtl/rk05_wd_pkg.sv
// rk05_wd_pkg
//   Shared definitions for the RK05 write-data decoder: the decoder state
//   encoding, default cell timing and helpers that derive the pulse
//   classification windows from the cell length (integer division).
package rk05_wd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam int DEF_CELL_CLKS    = 42;
  localparam int DEF_PREAMBLE_MIN = 16;

  // Earliest count at which an edge is accepted as a data pulse.
  function automatic int win_lo(input int cell_clks);
    return cell_clks / 4;
  endfunction

  // Earliest count at which an edge is accepted as a clock pulse.
  function automatic int win_hi(input int cell_clks);
    return (3 * cell_clks) / 4;
  endfunction

  // Count at which a silent line is treated as the end of the write.
  function automatic int tmo_clks(input int cell_clks);
    return 2 * cell_clks;
  endfunction

endpackage

// File: rtl/rk05_wt_data_decoder_edge_sync.sv
// rk05_edge_sync
//   Three-flop synchronizer for the asynchronous WT DATA & CLK pin with a
//   rising-edge detector on the two settled stages.
//   Ports:
//     clk  in   system clock
//     rst  in   synchronous active-high reset, clears all stages
//     pin  in   asynchronous composite clock/data line
//     rise out  one-cycle pulse when the synchronized line goes 0 -> 1
module rk05_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = pin;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s1 is the metastability catcher; only s2/s3 are used for the decision.
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/rk05_wt_data_decoder.sv
// rk05_wt_data_decoder
//   Decodes the RK05 double-frequency write line. Each bit cell opens with a
//   clock pulse; a pulse near mid-cell marks a 1. The decoder waits for a run
//   of zero cells followed by a sync 1, then emits bits and 16-bit words.
//   Ports:
//     C            in   system clock, rising edge
//     R            in   synchronous active-high reset
//     enable       in   write gate; low forces IDLE (word is kept)
//     wt_data_clk  in   asynchronous composite clock+data pulses
//     bit_valid    out  one-cycle strobe per decoded bit (DATA only)
//     bit_value    out  decoded bit, valid with bit_valid
//     word         out  last assembled word, MSB first, held
//     word_valid   out  one-cycle strobe, word updated in the same cycle
//     in_sync      out  high while in DATA
//     sync_err     out  one-cycle strobe on a framing error in DATA
//   Handshake: all strobes are single-cycle valid pulses with no ready; the
//   sector writer must accept bit/word on any cycle the strobe is high.
module rk05_wt_data_decoder
  import rk05_wd_pkg::*;
#(
  parameter int CELL_CLKS    = DEF_CELL_CLKS,
  parameter int PREAMBLE_MIN = DEF_PREAMBLE_MIN
) (
  input  logic        C,
  input  logic        R,
  input  logic        enable,
  input  logic        wt_data_clk,
  output logic        bit_valid,
  output logic        bit_value,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        in_sync,
  output logic        sync_err
);

  localparam int WIN_LO = win_lo(CELL_CLKS);
  localparam int WIN_HI = win_hi(CELL_CLKS);
  localparam int TMO    = tmo_clks(CELL_CLKS);
  localparam int CNT_W  = $clog2(TMO + 1);
  localparam int ZC_W   = $clog2(PREAMBLE_MIN + 1);

  localparam logic [CNT_W-1:0] WIN_LO_C = CNT_W'(WIN_LO);
  localparam logic [CNT_W-1:0] WIN_HI_C = CNT_W'(WIN_HI);
  localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TMO);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ZC_W-1:0]  PM_C     = ZC_W'(PREAMBLE_MIN);
  localparam logic [ZC_W-1:0]  ZC_ONE   = ZC_W'(1);

  logic rise;

  rk05_edge_sync u_edge_sync (
    .clk  (C),
    .rst  (R),
    .pin  (wt_data_clk),
    .rise (rise)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dseen_q, dseen_d;
  logic [ZC_W-1:0]   zc_q, zc_d;
  logic [3:0]        bcnt_q, bcnt_d;
  logic [15:0]       sh_q, sh_d;
  logic [15:0]       word_q, word_d;
  logic              bv_q, bv_d;
  logic              bval_q, bval_d;
  logic              wv_q, wv_d;
  logic              err_q, err_d;

  logic              is_spur, is_data;
  logic              to_idle;
  logic [15:0]       shifted;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dseen_d = dseen_q;
    zc_d    = zc_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    word_d  = word_q;
    bv_d    = 1'b0;
    bval_d  = 1'b0;
    wv_d    = 1'b0;
    err_d   = 1'b0;
    to_idle = 1'b0;

    // Edge class is decided by the count since the last accepted clock pulse.
    is_spur = (cnt_q < WIN_LO_C);
    is_data = !is_spur && (cnt_q < WIN_HI_C);
    shifted = {sh_q[14:0], dseen_q};

    if (state_q != ST_IDLE) begin
      cnt_d = (cnt_q == TMO_C) ? cnt_q : cnt_q + CNT_ONE;
    end

    if (!enable) begin
      to_idle = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The first edge seen is taken as a clock pulse opening a cell.
          if (rise) begin
            state_d = ST_LOCK;
            cnt_d   = '0;
            dseen_d = 1'b0;
            zc_d    = '0;
          end
        end

        ST_LOCK: begin
          if (rise) begin
            if (is_spur) begin
              zc_d = '0;
            end else if (is_data) begin
              dseen_d = 1'b1;
            end else begin
              cnt_d   = '0;
              dseen_d = 1'b0;
              if (!dseen_q) begin
                zc_d = (zc_q == PM_C) ? zc_q : zc_q + ZC_ONE;
              end else if (zc_q >= PM_C) begin
                // Sync bit: consumed here, never emitted.
                state_d = ST_DATA;
                bcnt_d  = '0;
                sh_d    = '0;
              end else begin
                zc_d = '0;
              end
            end
          end else if (cnt_q == TMO_C) begin
            to_idle = 1'b1;
          end
        end

        ST_DATA: begin
          if (rise) begin
            if (is_spur || (is_data && dseen_q)) begin
              err_d   = 1'b1;
              to_idle = 1'b1;
            end else if (is_data) begin
              dseen_d = 1'b1;
            end else begin
              cnt_d   = '0;
              dseen_d = 1'b0;
              bv_d    = 1'b1;
              bval_d  = dseen_q;
              sh_d    = shifted;
              if (bcnt_q == 4'd15) begin
                wv_d   = 1'b1;
                word_d = shifted;
                bcnt_d = '0;
              end else begin
                bcnt_d = bcnt_q + 4'd1;
              end
            end
          end else if (cnt_q == TMO_C) begin
            // Silent line: normal end of a write, not an error.
            to_idle = 1'b1;
          end
        end

        default: to_idle = 1'b1;
      endcase
    end

    // Leaving for IDLE drops any pending cell and partial word.
    if (to_idle) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      dseen_d = 1'b0;
      zc_d    = '0;
      bcnt_d  = '0;
      sh_d    = '0;
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dseen_q <= 1'b0;
      zc_q    <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      bv_q    <= 1'b0;
      bval_q  <= 1'b0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dseen_q <= dseen_d;
      zc_q    <= zc_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      word_q  <= word_d;
      bv_q    <= bv_d;
      bval_q  <= bval_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
    end
  end

  assign bit_valid  = bv_q;
  assign bit_value  = bval_q;
  assign word       = word_q;
  assign word_valid = wv_q;
  assign in_sync    = (state_q == ST_DATA);
  assign sync_err   = err_q;

endmodule

// File: tb/tb_rk05_wt_data_decoder.sv
// tb_rk05_wt_data_decoder
//   Directed bench for rk05_wt_data_decoder. A cycle model driven from the
//   sampled inputs predicts every output; literal checks pin lock latency,
//   decoded words, strobe counts and the write-end timeout.
module tb_rk05_wt_data_decoder;

  localparam int CELL   = 42;
  localparam int PM     = 16;
  localparam int WIN_LO = CELL / 4;
  localparam int WIN_HI = (3 * CELL) / 4;
  localparam int TMO    = 2 * CELL;
  localparam int M_IDLE = 0;
  localparam int M_LOCK = 1;
  localparam int M_DATA = 2;

  // ---------------- clock / reset ----------------
  logic        C = 1'b0;
  logic        R = 1'b1;
  logic        enable = 1'b0;
  logic        wt_data_clk = 1'b0;
  logic        bit_valid, bit_value, word_valid, in_sync, sync_err;
  logic [15:0] word;

  always #5 C = ~C;

  rk05_wt_data_decoder dut (
    .C           (C),
    .R           (R),
    .enable      (enable),
    .wt_data_clk (wt_data_clk),
    .bit_valid   (bit_valid),
    .bit_value   (bit_value),
    .word        (word),
    .word_valid  (word_valid),
    .in_sync     (in_sync),
    .sync_err    (sync_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        smp_r, smp_en, smp_pin;
  always @(posedge C) begin
    smp_r   <= R;
    smp_en  <= enable;
    smp_pin <= wt_data_clk;
  end

  logic [2:0]  m_ph = 3'b000;  // pin samples, [0] newest
  int          m_mode = M_IDLE;
  int          m_cyc = 0;
  int          m_last = 0;     // cycle of last accepted clock pulse
  int          m_dcnt = 0;     // data pulses seen in the open cell
  int          m_zeros = 0;
  bit          m_bits[$];
  logic [15:0] m_word = 16'h0;
  logic        e_bv, e_bval, e_wv, e_err;
  logic [15:0] exp_q[$];

  task automatic model_step();
    int   cnt;
    logic ev;
    logic b;
    e_bv = 1'b0; e_bval = 1'b0; e_wv = 1'b0; e_err = 1'b0;
    ev  = m_ph[1] & ~m_ph[2];
    cnt = m_cyc - m_last - 1;
    if (cnt > TMO) cnt = TMO;
    if (smp_r) begin
      m_ph = 3'b000; m_mode = M_IDLE; m_word = 16'h0;
    end else begin
      m_ph = {m_ph[1:0], smp_pin};
      if (!smp_en) begin
        m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (ev) begin
          m_mode = M_LOCK; m_last = m_cyc; m_dcnt = 0; m_zeros = 0;
        end
      end else if (ev) begin
        if (cnt < WIN_LO) begin
          if (m_mode == M_DATA) begin e_err = 1'b1; m_mode = M_IDLE; end
          else m_zeros = 0;
        end else if (cnt < WIN_HI) begin
          if (m_mode == M_DATA && m_dcnt > 0) begin e_err = 1'b1; m_mode = M_IDLE; end
          else m_dcnt++;
        end else begin
          b = (m_dcnt > 0);
          m_last = m_cyc;
          m_dcnt = 0;
          if (m_mode == M_LOCK) begin
            if (!b) m_zeros = (m_zeros < PM) ? m_zeros + 1 : PM;
            else if (m_zeros >= PM) begin m_mode = M_DATA; m_bits.delete(); end
            else m_zeros = 0;
          end else begin
            e_bv = 1'b1; e_bval = b;
            m_bits.push_back(b);
            if (m_bits.size() == 16) begin
              foreach (m_bits[i]) m_word[15-i] = m_bits[i];
              e_wv = 1'b1;
              exp_q.push_back(m_word);
              m_bits.delete();
            end
          end
        end
      end else if (cnt == TMO) begin
        m_mode = M_IDLE;
      end
    end
    m_cyc++;
  endtask

  // ---------------- compare / scoreboard ----------------
  int          bv_cnt = 0;
  int          wv_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] dut_bits = 16'h0;

  initial begin
    logic [20:0] got, exp;
    logic [15:0] w;
    forever begin
      @(negedge C);
      model_step();
      exp = {e_bv, e_bv & e_bval, e_wv, (m_mode == M_DATA), e_err, m_word};
      got = {bit_valid, e_bv & bit_value, word_valid, in_sync, sync_err, word};
      check("cycle_outputs", 32'(got), 32'(exp));
      if (bit_valid) begin bv_cnt++; dut_bits = {dut_bits[14:0], bit_value}; end
      if (sync_err) err_cnt++;
      if (word_valid) begin
        wv_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_word: got %0h expected none pending", word);
        end else begin
          w = exp_q.pop_front();
          check("sb_word", 32'(word), 32'(w));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Rising edges are spaced 'gap' clocks apart; each pulse is 2 clocks wide.
  task automatic gap_pulse(input int gap);
    repeat (gap - 2) @(negedge C);
    wt_data_clk = 1'b1;
    repeat (2) @(negedge C);
    wt_data_clk = 1'b0;
  endtask

  task automatic lock_seq(input int nzero, input bit first, input bit expect_sync);
    if (first) gap_pulse(3);
    repeat (nzero) gap_pulse(42);
    gap_pulse(22);
    gap_pulse(20);
    check("sync_before_k3", 32'(in_sync), 32'd0);
    @(negedge C);
    check("sync_at_k3", 32'(in_sync), 32'(expect_sync));
  endtask

  // Data at cnt 21 / period 42, or with jitter: periods 41/43, data cnt 10/30.
  task automatic send_bits(input logic [15:0] w, input int nbits, input bit jitter);
    int per, dpos;
    for (int i = 0; i < nbits; i++) begin
      per  = jitter ? ((i % 2 == 1) ? 43 : 41) : 42;
      dpos = jitter ? ((i % 2 == 1) ? 31 : 11) : 22;
      if (w[15-i]) begin
        gap_pulse(dpos);
        gap_pulse(per - dpos);
      end else begin
        gap_pulse(per);
      end
    end
  endtask

  task automatic clear_mon();
    bv_cnt = 0; wv_cnt = 0; err_cnt = 0; dut_bits = 16'h0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run;
    repeat (3) @(negedge C);
    check("reset_outputs", 32'({bit_valid, bit_value, word_valid, in_sync, sync_err, word}), 32'd0);
    R = 1'b0; enable = 1'b1;
    repeat (5) @(negedge C);

    // Lock on 16 zeros + sync, no bit strobes during lock.
    clear_mon();
    lock_seq(16, 1'b1, 1'b1);
    check("lock_no_bits", 32'(bv_cnt), 32'd0);

    // One word, MSB first.
    clear_mon();
    send_bits(16'hA5C3, 16, 1'b0);
    @(negedge C);
    check("a5c3_bits", 32'(dut_bits), 32'hA5C3);
    check("a5c3_bv_cnt", 32'(bv_cnt), 32'd16);
    check("a5c3_wv_cnt", 32'(wv_cnt), 32'd1);
    check("a5c3_word", 32'(word), 32'hA5C3);

    // Spurious edge at cnt 5 in DATA.
    clear_mon();
    send_bits(16'hC000, 2, 1'b0);
    gap_pulse(6);
    @(negedge C);
    check("spur_err_cnt", 32'(err_cnt), 32'd1);
    check("spur_in_sync", 32'(in_sync), 32'd0);
    check("spur_no_word", 32'(wv_cnt), 32'd0);
    repeat (120) @(negedge C);

    // 15 zeros are not enough; 16 more then sync locks.
    lock_seq(15, 1'b1, 1'b0);
    lock_seq(16, 1'b0, 1'b1);

    // Two data pulses in one cell (cnt 12, 25).
    clear_mon();
    gap_pulse(12);
    gap_pulse(13);
    @(negedge C);
    check("dbl_err_cnt", 32'(err_cnt), 32'd1);
    check("dbl_in_sync", 32'(in_sync), 32'd0);
    check("dbl_no_word", 32'(wv_cnt), 32'd0);
    repeat (120) @(negedge C);

    // Jittered cells and window-edge data, then the line goes quiet.
    lock_seq(16, 1'b1, 1'b1);
    clear_mon();
    send_bits(16'h5A3C, 16, 1'b1);
    run = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge C);
      if (in_sync) run++;
      else break;
    end
    check("tmo_cycles", 32'(run), 32'd85);
    check("jit_word", 32'(word), 32'h5A3C);
    check("jit_bits", 32'(dut_bits), 32'h5A3C);
    check("tmo_no_err", 32'(err_cnt), 32'd0);

    // Reset mid-word clears everything including word.
    lock_seq(16, 1'b1, 1'b1);
    clear_mon();
    send_bits(16'hF0F0, 8, 1'b0);
    R = 1'b1;
    @(negedge C);
    R = 1'b0;
    check("rst_outputs", 32'({bit_valid, bit_value, word_valid, in_sync, sync_err, word}), 32'd0);
    check("rst_no_word", 32'(wv_cnt), 32'd0);
    lock_seq(16, 1'b1, 1'b1);
    send_bits(16'h1234, 16, 1'b0);
    @(negedge C);
    check("relock_word", 32'(word), 32'h1234);

    // Enable low mid-word: strobes and sync drop, word is held.
    clear_mon();
    send_bits(16'h00FF, 8, 1'b0);
    enable = 1'b0;
    @(negedge C);
    enable = 1'b1;
    check("en_outputs", 32'({bit_valid, word_valid, in_sync, sync_err}), 32'd0);
    check("en_word_held", 32'(word), 32'h1234);
    check("en_no_word", 32'(wv_cnt), 32'd0);
    lock_seq(16, 1'b1, 1'b1);
    send_bits(16'h8001, 16, 1'b0);
    @(negedge C);
    check("en_relock_word", 32'(word), 32'h8001);

    repeat (10) @(negedge C);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rk05_wt_data_decoder.md
# rk05_wt_data_decoder

Receive-side decoder for the RK05 composite double-frequency write-data line (WT DATA & CLK) driven by the disk controller into the emulator. Synchronizes the asynchronous pin, classifies each pulse as a clock or a data pulse by position within the bit cell, and locks onto the sector preamble/sync bit. After lock it emits decoded bits and assembled 16-bit words to the sector buffer write path. It sits between the controller-facing input pins and the emulator's sector memory writer.

## Interface
- CELL_CLKS, 42: FPGA clocks per bit cell (60 MHz / 1.44 Mb/s)
- PREAMBLE_MIN, 16: minimum consecutive zero cells before a sync 1 is accepted
- C  in  1  system clock; everything is on the rising edge
- R  in  1  reset, synchronous, active-high
- enable  in  1  write gate, already synchronous to C; low forces IDLE
- wt_data_clk  in  1  asynchronous composite clock+data pulses from controller
- bit_valid  out  1  one-cycle strobe per decoded data bit (DATA state only)
- bit_value  out  1  decoded bit; valid with bit_valid
- word  out  16  last assembled word, MSB first; held between updates
- word_valid  out  1  one-cycle strobe; word updated in the same cycle
- in_sync  out  1  high while in DATA state
- sync_err  out  1  one-cycle strobe on a framing error in DATA

## Operation
- Derived constants: WIN_LO = CELL_CLKS/4 (10), WIN_HI = 3*CELL_CLKS/4 (31), TMO = 2*CELL_CLKS (84), all integer division.
- Pin path: s1 <= pin, s2 <= s1, s3 <= s2; edge = s2 & ~s3.
- cnt: clocks since last accepted clock pulse; saturates at TMO; width clog2(TMO+1).
- Edge classification by cnt: cnt < WIN_LO spurious; WIN_LO <= cnt < WIN_HI data pulse (sets dseen); cnt >= WIN_HI clock pulse (closes cell: bit = dseen; cnt <= 0; dseen <= 0).
- States IDLE, LOCK, DATA. Reset/enable low -> IDLE, cnt, dseen, zero_cnt, bit counter, shift register cleared; word holds its last value except on R (cleared).
- IDLE: first edge -> treated as clock pulse, go LOCK, zero_cnt <= 0.
- LOCK: closed cell bit 0 -> zero_cnt++ (saturating at PREAMBLE_MIN). Bit 1 with zero_cnt >= PREAMBLE_MIN -> DATA, sync bit not emitted, bit counter <= 0. Bit 1 otherwise, or spurious edge -> zero_cnt <= 0, stay LOCK. No outputs pulse in LOCK.
- DATA: each closed cell -> bit_valid, bit_value; shift in MSB first; 16th bit -> word_valid, word <= shifted value, bit counter wraps to 0.
- DATA errors: spurious edge, or second data pulse in one cell (dseen already set) -> sync_err, go IDLE, partial word discarded.
- Timeout: cnt reaches TMO in LOCK or DATA -> IDLE, no sync_err (normal end of write), pending cell and partial word discarded.
- Simultaneous: enable low or R wins over any edge in the same cycle; timeout and edge in the same cycle -> edge processed, no timeout.

## Timing
- Reset value of all outputs 0; state IDLE; s1..s3 = 0.
- Pin rising edge sampled into s1 at cycle k -> edge at k+2 -> bit_valid/word_valid/sync_err/state change registered at k+3.
- in_sync rises at k+3 of the clock pulse closing the sync cell.
- bit_value and bit_valid coincide; word_valid coincides with the 16th bit_valid.
- Pulse widths >= 2 clocks are required for reliable edge capture.

## Structure
- Package rk05_wd_pkg: state enum (IDLE, LOCK, DATA), default CELL_CLKS and PREAMBLE_MIN, derived window function.
- Sub-module rk05_edge_sync: 3-flop synchronizer plus rising-edge detect, reset clears to 0.

## Test plan
- 16 zero cells at 42-clock spacing, then cell with data pulse at cnt 21, then clock pulse -> in_sync = 1 three cycles after that pin edge; no bit_valid before.
- After lock, send 0xA5C3 MSB first -> 16 bit_valid strobes with bits 1010_0101_1100_0011; single word_valid with word = 16'hA5C3.
- 15 zeros then a 1 -> stays LOCK, in_sync 0; then 16 zeros and a 1 -> in_sync 1.
- In DATA, edge at cnt 5 -> sync_err one cycle, in_sync 0 next; no word_valid; same with two data pulses at cnt 12 and 25.
- Jitter: clock spacing alternating 41/43, data pulses at cnt 10 and 30 -> all bits decoded correctly; then pin idle -> IDLE at cnt 84, sync_err stays 0.
- After 8 bits, assert R one cycle (repeat with enable low) -> all outputs 0 next cycle, no word_valid; relock from fresh preamble succeeds.
